// File: rtl/ccff_loader.sv
// Configuration-chain loader: splits bitstream words across NUM_CHAINS serial
// chains, shifting CHAIN_LEN bits into each, with optional tail read-back verify.
module ccff_loader #(
    parameter int NUM_CHAINS = 1,
    parameter int CHAIN_LEN  = 64,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  verify,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  prog_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int SPW = DATA_W / NUM_CHAINS;
    localparam int CW  = $clog2(CHAIN_LEN + 1);
    localparam int WW  = $clog2(SPW + 1);

    if ((DATA_W % NUM_CHAINS) != 0 || NUM_CHAINS < 1 || NUM_CHAINS > 8 || CHAIN_LEN < 1) begin : g_bad_params
        $error("ccff_loader: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_WORD = 2'd1,
        S_SHIFT     = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    state_t                  state_q;
    logic [DATA_W-1:0]       buf_q;
    logic [NUM_CHAINS-1:0]   head_q;
    logic [CW-1:0]           tot_q;
    logic [WW-1:0]           wcnt_q;
    logic                    verify_q;
    logic                    data_ready_q;
    logic                    prog_en_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;

    logic [CW-1:0]           tot_d;
    logic [WW-1:0]           wcnt_d;
    logic                    chain_end_d;
    logic                    word_end_d;
    logic                    mismatch_d;

    // Shift bookkeeping and tail comparison for the current SHIFT cycle.
    always_comb begin
        tot_d       = tot_q + CW'(1);
        wcnt_d      = wcnt_q + WW'(1);
        chain_end_d = (tot_q == CW'(CHAIN_LEN - 1));
        word_end_d  = (wcnt_q == WW'(SPW - 1));
        mismatch_d  = |(ccff_tail ^ head_q);
    end

    // Loader FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge pReset) begin
        if (pReset) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            head_q       <= '0;
            tot_q        <= '0;
            wcnt_q       <= '0;
            verify_q     <= 1'b0;
            data_ready_q <= 1'b0;
            prog_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                // Abort wins over everything; error is deliberately kept.
                state_q      <= S_IDLE;
                head_q       <= '0;
                data_ready_q <= 1'b0;
                prog_en_q    <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q      <= S_WAIT_WORD;
                            busy_q       <= 1'b1;
                            error_q      <= 1'b0;
                            verify_q     <= verify;
                            tot_q        <= '0;
                            wcnt_q       <= '0;
                            data_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_WAIT_WORD: begin
                        if (data_valid) begin
                            state_q      <= S_SHIFT;
                            head_q       <= data_in[NUM_CHAINS-1:0];
                            buf_q        <= data_in >> NUM_CHAINS;
                            wcnt_q       <= '0;
                            data_ready_q <= 1'b0;
                            prog_en_q    <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_WORD;
                        end
                    end
                    S_SHIFT: begin
                        tot_q  <= tot_d;
                        wcnt_q <= wcnt_d;
                        if (chain_end_d) begin
                            state_q   <= S_FINISH;
                            head_q    <= '0;
                            prog_en_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (word_end_d) begin
                            state_q      <= S_WAIT_WORD;
                            head_q       <= '0;
                            prog_en_q    <= 1'b0;
                            data_ready_q <= 1'b1;
                        end else begin
                            head_q <= buf_q[NUM_CHAINS-1:0];
                            buf_q  <= buf_q >> NUM_CHAINS;
                        end
                    end
                    S_FINISH: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
            // The chains shift on this edge even when aborting, so the compare still counts.
            if (state_q == S_SHIFT && verify_q && mismatch_d) begin
                error_q <= 1'b1;
            end
        end
    end

    assign data_ready = data_ready_q;
    assign ccff_head  = head_q;
    assign prog_en    = prog_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Randomized self-checking bench for ccff_loader (2 chains x 6 FFs, 8-bit words)
// against a bitstream-level reference model.
module tb_ccff_loader;

    localparam int NC = 2;
    localparam int L  = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          pReset = 1'b1;
    logic          start = 1'b0;
    logic          verify = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [NC-1:0] ccff_head;
    logic [NC-1:0] ccff_tail;
    logic          prog_en;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int failures = 0;

    // Physical chains driven by the DUT; ec is the model's expected content (bit 0 exits next).
    logic [L-1:0] chain [NC] = '{default: '0};
    logic [L-1:0] ec [NC] = '{default: '0};
    bit           exp_err = 1'b0;

    ccff_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .DATA_W(DW)) dut (
        .clk(clk), .pReset(pReset), .start(start), .verify(verify), .abort(abort),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_en(prog_en),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (prog_en) begin
            for (int c = 0; c < NC; c++) chain[c] <= {chain[c][L-2:0], ccff_head[c]};
        end
    end

    always_comb begin
        for (int c = 0; c < NC; c++) ccff_tail[c] = chain[c][L-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_shift(input logic [NC-1:0] b, input bit vfy);
        for (int c = 0; c < NC; c++) begin
            if (vfy && ec[c][0] != b[c]) exp_err = 1'b1;
            ec[c] = {b[c], ec[c][L-1:1]};
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, data_ready}, 32'd0);
        check({tag, "_prog"},  {31'd0, prog_en},    32'd0);
        check({tag, "_head"},  {30'd0, ccff_head},  32'd0);
        check({tag, "_busy"},  {31'd0, busy},       32'd0);
        check({tag, "_done"},  {31'd0, done},       32'd0);
        check({tag, "_err"},   {31'd0, error},      32'd0);
    endtask

    // One pass: words w0,w1; gap = idle cycles before each word; abort/reset at a shift index (-1 = none).
    task automatic run_pass(input logic [7:0] w0, input logic [7:0] w1, input bit vfy,
                            input int gap, input int abort_at, input int reset_at,
                            input bit extra_start);
        logic [15:0] strm;
        logic [7:0]  words [2];
        int nsh, widx, gcnt, ndone, nready;
        bit ended, pe_prev, ab_pending, was_reset;
        strm = {w1, w0};
        words[0] = w0; words[1] = w1;
        nsh = 0; widx = 0; gcnt = gap; ndone = 0; nready = 0;
        ended = 1'b0; pe_prev = 1'b0; ab_pending = 1'b0; was_reset = 1'b0;
        @(negedge clk);
        start = 1'b1; verify = vfy; abort = 1'b0;
        data_in = w0; data_valid = 1'b1;
        exp_err = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (ab_pending) begin
                check("abort_busy",  {31'd0, busy},       32'd0);
                check("abort_prog",  {31'd0, prog_en},    32'd0);
                check("abort_done",  {31'd0, done},       32'd0);
                check("abort_ready", {31'd0, data_ready}, 32'd0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("abort_nodone", {31'd0, done}, 32'd0);
                end
                ended = 1'b1;
                break;
            end
            check("err_track", {31'd0, error}, {31'd0, exp_err});
            if (!prog_en) check("head_idle0", {30'd0, ccff_head}, 32'd0);
            if (done) begin
                ndone++;
                check("done_after_shift", {31'd0, pe_prev}, 32'd1);
                check("done_busy", {31'd0, busy}, 32'd0);
                @(negedge clk);
                check("done_one_cycle", {31'd0, done}, 32'd0);
                check("idle_busy", {31'd0, busy}, 32'd0);
                ended = 1'b1;
                break;
            end
            check("busy_in_pass", {31'd0, busy}, 32'd1);
            if (prog_en) begin
                check("head", {30'd0, ccff_head}, {30'd0, strm[2*nsh +: 2]});
                check("ready_in_shift", {31'd0, data_ready}, 32'd0);
                if (reset_at == nsh) begin
                    pReset = 1'b1;
                    #1;
                    check_all_zero("async_rst");
                    @(negedge clk);
                    @(negedge clk);
                    pReset = 1'b0;
                    exp_err = 1'b0;
                    was_reset = 1'b1;
                    ended = 1'b1;
                    break;
                end
                model_shift(strm[2*nsh +: 2], vfy);
                if (abort_at == nsh) begin
                    abort = 1'b1;
                    ab_pending = 1'b1;
                end
                nsh++;
            end
            data_in = words[widx < 2 ? widx : 1];
            if (data_ready) begin
                nready++;
                if (gcnt > 0) begin
                    data_valid = 1'b0;
                    gcnt--;
                end else begin
                    data_valid = (widx < 2);
                    widx++;
                    gcnt = gap;
                end
            end else begin
                data_valid = (widx < 2);
            end
            if (extra_start && cyc == 0) start = 1'b1;
            pe_prev = prog_en;
        end
        data_valid = 1'b0;
        if (!ended) check("timeout", 32'd1, 32'd0);
        if (was_reset) begin
            check("rst_shifts", nsh, reset_at);
        end else if (abort_at >= 0) begin
            check("abort_shifts", nsh, abort_at + 1);
            check("abort_ndone", ndone, 0);
            check("abort_err_kept", {31'd0, error}, {31'd0, exp_err});
        end else begin
            check("pass_shifts", nsh, L);
            check("pass_ndone", ndone, 1);
            check("pass_words", widx, 2);
            check("pass_ready_cycles", nready, 2 * (gap + 1));
            check("pass_err", {31'd0, error}, {31'd0, exp_err});
        end
    endtask

    initial begin
        logic [7:0] pw0, pw1;
        bit v;
        int ab;
        pReset = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        pReset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        run_pass(8'hB4, 8'h0E, 1'b0, 0, -1, -1, 1'b0);
        run_pass(8'hB4, 8'h0E, 1'b1, 0, -1, -1, 1'b0);
        check("verify_match_err", {31'd0, error}, 32'd0);
        run_pass(8'hB5, 8'h0E, 1'b1, 0, -1, -1, 1'b0);
        check("verify_mismatch_err", {31'd0, error}, 32'd1);
        run_pass(8'h5A, 8'h33, 1'b0, 5, -1, -1, 1'b0);
        check("start_clears_err", {31'd0, error}, 32'd0);
        run_pass(8'hC3, 8'h71, 1'b0, 0, 2, -1, 1'b1);
        run_pass(8'h96, 8'h28, 1'b0, 0, -1, 3, 1'b0);
        run_pass(8'hB4, 8'h0E, 1'b0, 1, -1, -1, 1'b0);

        pw0 = 8'hB4; pw1 = 8'h0E;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                pw0 = 8'($urandom);
                pw1 = 8'($urandom);
            end
            v  = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L - 1)) : -1;
            run_pass(pw0, pw1, v, int'($urandom_range(0, 3)), ab, -1,
                     1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
